// File: rtl/onehot_dec_pkg.sv
// ---------------------------------------------------------------------------
// onehot_dec_pkg
//   Shared types and helpers for the one-hot decoder controller.
//   - dec_mode_e  : command mode encoding on in_mode.
//   - dec_state_e : controller state encoding.
//   - rotl1       : one-position left rotate over the low 'w' bits of a
//                   MAX_OUT_W-wide vector (bits at and above 'w' return 0).
//   Decoders using rotl1 are limited to SEL_W <= MAX_SEL_W.
// ---------------------------------------------------------------------------
package onehot_dec_pkg;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_CLEAR  = 2'b11
    } dec_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PULSE = 2'b01,
        S_SCAN  = 2'b10
    } dec_state_e;

    // Rotate left by one within a window of 'w' bits: bit w-1 wraps to bit 0.
    // Shifts are used instead of variable bit-selects to keep index widths
    // out of the picture.
    function automatic logic [MAX_OUT_W-1:0] rotl1(input logic [MAX_OUT_W-1:0] v,
                                                   input int unsigned         w);
        logic [MAX_OUT_W-1:0] wrap;
        logic [MAX_OUT_W-1:0] mask;
        wrap = (v >> (w - 1)) & MAX_OUT_W'(1);
        if (w >= MAX_OUT_W)
            mask = {MAX_OUT_W{1'b1}};
        else
            mask = (MAX_OUT_W'(1) << w) - MAX_OUT_W'(1);
        return ((v << 1) | wrap) & mask;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// ---------------------------------------------------------------------------
// onehot_dec
//   Purely combinational binary-to-one-hot map: hot = 1 << sel.
//   Ports:
//     sel : SEL_W-bit binary index (always in range by construction)
//     hot : 2**SEL_W-bit one-hot result
// ---------------------------------------------------------------------------
module onehot_dec
    import onehot_dec_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] hot
);

    always_comb begin
        hot      = '0;
        hot[sel] = 1'b1;
    end

endmodule

// File: rtl/onehot_decoder_ctl.sv
// ---------------------------------------------------------------------------
// onehot_decoder_ctl
//   Registered binary-to-one-hot decoder with a valid/ready command port and
//   three output modes: static, timed pulse and rotating scan. Every bit of
//   'out' comes straight from a flop, so the select lines are glitch-free.
//
//   Handshake: a command transfers on a rising edge where in_valid and
//   in_ready are both high. in_ready is high only in IDLE; in_valid while
//   in_ready is low is dropped, so the source must hold its command.
//
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     in_valid   : command valid          in_ready : command accepted when high
//     in_sel     : binary index           in_mode  : 00 static, 01 pulse,
//     in_hold    : dwell, lasts hold+1               10 scan, 11 clear
//     in_stop    : abort pulse/scan       out      : registered one-hot select
//     busy       : pulse or scan running
//
//   Build option: ONEHOT_DEC_ACTIVE_LOW_EN makes 'out' one-cold (idle value
//   all-ones). The inversion sits in front of the output register.
//   SEL_W must not exceed onehot_dec_pkg::MAX_SEL_W.
// ---------------------------------------------------------------------------
module onehot_decoder_ctl
    import onehot_dec_pkg::*;
#(
    parameter int SEL_W  = 3,
    parameter int HOLD_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [1:0]            in_mode,
    input  logic [HOLD_W-1:0]     in_hold,
    input  logic                  in_stop,
    output logic [(1<<SEL_W)-1:0] out,
    output logic                  busy
);

    localparam int OUT_W = 1 << SEL_W;

    // Map between the internal active-high "hot" view and the pin polarity.
    // Self-inverse, so it serves both directions.
    function automatic logic [OUT_W-1:0] to_pin(input logic [OUT_W-1:0] hot);
`ifdef ONEHOT_DEC_ACTIVE_LOW_EN
        return ~hot;
`else
        return hot;
`endif
    endfunction

    dec_state_e        state_q, state_d;
    logic [HOLD_W-1:0] cnt_q,   cnt_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [OUT_W-1:0]  out_q,   out_d;

    logic [OUT_W-1:0]  dec_hot;
    logic [OUT_W-1:0]  cur_hot;
    logic [OUT_W-1:0]  rot_hot;
    logic [OUT_W-1:0]  hot_d;
    logic              accept;

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel (in_sel),
        .hot (dec_hot)
    );

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign accept   = in_valid && in_ready;
    assign out      = out_q;

    // Current select in active-high form; only feeds next-state logic.
    assign cur_hot  = to_pin(out_q);
    assign rot_hot  = OUT_W'(rotl1(MAX_OUT_W'(cur_hot), OUT_W));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        hot_d   = cur_hot;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (dec_mode_e'(in_mode))
                        MODE_STATIC: hot_d = dec_hot;
                        MODE_PULSE: begin
                            hot_d   = dec_hot;
                            cnt_d   = in_hold;
                            state_d = S_PULSE;
                        end
                        MODE_SCAN: begin
                            hot_d   = dec_hot;
                            cnt_d   = in_hold;
                            hold_d  = in_hold;
                            state_d = S_SCAN;
                        end
                        MODE_CLEAR: hot_d = '0;
                        default:    hot_d = '0;
                    endcase
                end
            end

            // Stop is checked first so it wins over expiry in the same cycle.
            S_PULSE: begin
                if (in_stop) begin
                    hot_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end else begin
                    hot_d   = '0;
                    state_d = S_IDLE;
                end
            end

            // Stop is checked first so no rotated value ever reaches 'out'.
            S_SCAN: begin
                if (in_stop) begin
                    hot_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end else begin
                    hot_d = rot_hot;
                    cnt_d = hold_q;
                end
            end

            default: begin
                hot_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        out_d = to_pin(hot_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            out_q   <= to_pin('0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: doc/onehot_decoder_ctl.md
# onehot_decoder_ctl

Parametrised, registered binary-to-one-hot decoder with a valid/ready command port and three output modes: static, timed pulse and rotating scan. It generalises the team's fixed 3-to-8 combinational decoder. It sits between control logic and one-hot consumers: row/bank selects, LED/segment digit strobes and multiplexed-display scanning. Outputs are glitch-free because every output bit comes straight from a flop.

## Interface
Parameters:
- `SEL_W`, default 3: select width; output width is `OUT_W = 2**SEL_W` (8 by default).
- `HOLD_W`, default 8: width of the dwell/pulse-length field.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: command valid.
- `in_ready` output 1: block can accept a command.
- `in_sel` input `SEL_W`: binary index to decode.
- `in_mode` input 2: 00 static, 01 pulse, 10 scan, 11 clear.
- `in_hold` input `HOLD_W`: dwell value; each position or pulse lasts `in_hold+1` cycles.
- `in_stop` input 1: aborts a pulse or scan.
- `out` output `OUT_W`: registered one-hot (or all-zero) select.
- `busy` output 1: pulse or scan in progress.

## Operation
- States: IDLE, PULSE, SCAN.
- `in_ready` = 1 only in IDLE. Accept = `in_valid && in_ready`.
- Accept in IDLE:
  - mode 00: `out <= 1<<in_sel`; state stays IDLE. `out` holds until the next accept or reset.
  - mode 01: `out <= 1<<in_sel`; `cnt <= in_hold`; go to PULSE.
  - mode 10: `out <= 1<<in_sel`; `cnt <= in_hold`; `hold_r <= in_hold`; go to SCAN.
  - mode 11: `out <= 0`; state stays IDLE.
- PULSE:
  - while `cnt != 0`: decrement `cnt`.
  - when `cnt == 0`: `out <= 0`, go to IDLE.
- SCAN:
  - while `cnt != 0`: decrement `cnt`.
  - when `cnt == 0`: rotate `out` left by one (bit `OUT_W-1` wraps to bit 0); `cnt <= hold_r`.
  - Scan runs until stopped.
- `in_stop` in PULSE or SCAN: `out <= 0`, go to IDLE. `in_stop` has priority over an expiry or rotation in the same cycle. `in_stop` in IDLE is ignored.
- `in_valid` while `in_ready` is 0 is ignored (not queued). The source must hold the command.
- `busy` = (state != IDLE).
- `in_sel` is always in range because its width is exactly `SEL_W`. `out` never has more than one bit set.
- Reset (`rst_n` low at an edge), at any point including mid-pulse or mid-scan: state IDLE, `out = 0`, `cnt = 0`, `hold_r = 0`.

## Timing
- Reset values: `out = 0`, `busy = 0`, `in_ready = 1` (combinational from state, so it is 1 from the first post-reset cycle).
- Decode latency: `out` changes one cycle after the accepting edge.
- Pulse: `out` is one-hot for exactly `in_hold+1` cycles. `in_ready` returns high in the cycle `out` becomes 0.
- Scan: each position is held `hold_r+1` cycles. A full rotation takes `OUT_W*(hold_r+1)` cycles.
- Stop: `out = 0` and `in_ready = 1` one cycle after the edge where `in_stop` is sampled. A new command can be accepted on the next edge.
- Back-to-back static or clear commands: one accept per cycle.

## Configuration
- Macro `ONEHOT_DEC_ACTIVE_LOW_EN`.
- Defined: `out` is one-cold (the driven bit is 0, all others 1). Reset, clear, stop and pulse-expiry values are all-ones. The internal state machine is unchanged; inversion is applied at the output register input, never combinationally after it.
- Undefined: active-high behaviour as described above.

## Structure
- Package `onehot_dec_pkg`:
  - enum `dec_mode_e` (MODE_STATIC, MODE_PULSE, MODE_SCAN, MODE_CLEAR);
  - enum `dec_state_e` (S_IDLE, S_PULSE, S_SCAN);
  - function `rotl1` for the one-position left rotate.
- Sub-module `onehot_dec`: purely combinational, parametrised by `SEL_W`, maps `sel` to `1<<sel`. The top level instantiates it once on `in_sel`.
- Counter, state register and output register live in the top level.

## Test plan
- Reset, then static: `SEL_W`=3; apply `rst_n`=0 then 1; send mode 00, sel 5 → `out`=8'b0010_0000 from the next cycle and held 20 cycles. Then mode 11 → `out`=0.
- Pulse: mode 01, sel 2, hold 3 → `out`=8'h04 for exactly 4 cycles, then 0. `in_ready`=0 during the pulse. A second `in_valid` during the pulse is ignored.
- Scan with wrap: mode 10, sel 6, hold 1 → `out` sequence 0x40,0x40,0x80,0x80,0x01,0x01,0x02… Then `in_stop` → `out`=0 and `busy`=0 the next cycle.
- Stop/rotation collision: scan with hold 0, assert `in_stop` on a rotation cycle → `out`=0 with no extra rotated value.
- Reset mid-scan: pull `rst_n` low during scan → `out`=0, `busy`=0, `in_ready`=1 after that edge. A following mode 00, sel 0 → `out`=0x01.
- Active-low build (`ONEHOT_DEC_ACTIVE_LOW_EN`), `SEL_W`=4: reset → `out`=16'hFFFF; mode 00, sel 9 → `out`=16'hFDFF.
